// File: rtl/frame_cdc_buffer.sv
// Dual-clock frame buffer: words are written on wrClk, committed a whole frame at a time,
// and streamed out on rdClk. Pointers cross the clock domains in Gray code.
module frame_cdc_buffer #(
  parameter int WIDTH       = 16,
  parameter int DEPTHLOG2   = 12,
  parameter int FRAMELOG2   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCHLOG2 = 26
) (
  input  logic                         wrClk,
  input  logic                         rst,
  input  logic                         wrValid,
  input  logic [WIDTH-1:0]             wrData,
  input  logic                         wrAbort,
  output logic                         wrFull,
  output logic                         wrDropping,
  output logic [15:0]                  ovfCount,
  output logic                         dataOverf,
  input  logic                         rdClk,
  input  logic                         rdReady,
  output logic [WIDTH-1:0]             rdData,
  output logic                         rdValid,
  input  logic                         rdRewind,
  output logic                         rdFrameReady,
  output logic [DEPTHLOG2-FRAMELOG2:0] rdFramesAvail
);

  localparam int DEPTH = 2 ** DEPTHLOG2;
  localparam int FCW   = DEPTHLOG2 - FRAMELOG2 + 1;

  typedef logic [DEPTHLOG2-1:0] ptrT;

  function automatic ptrT toGray(input ptrT b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptrT fromGray(input ptrT g);
    ptrT b;
    b[DEPTHLOG2-1] = g[DEPTHLOG2-1];
    for (int i = DEPTHLOG2 - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  // write-domain state
  ptrT wp, cwp, wpInc, cwpGray, rpRelSync;
  ptrT rpRelGraySync [SYNC_STAGES];
  logic [STRETCHLOG2-1:0] stretchCnt;
  logic doWrite, overflow;

  // read-domain state
  ptrT rp, rpRel, rpInc, rpNext, rpRelGray, cwpSync, framesDiff;
  ptrT cwpGraySync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] rdRstPipe;
  logic rdRst, consume;

  // ---------------------------------------------------------------- write side
  always_comb begin
    wpInc    = wp + 1'b1;
    wrFull   = (wpInc == rpRelSync);
    doWrite  = wrValid & ~wrFull & ~wrDropping & ~wrAbort & ~rst;
    overflow = wrValid & wrFull & ~wrDropping & ~wrAbort & ~rst;
  end

  always_ff @(posedge wrClk) begin
    if (rst) begin
      wp         <= '0;
      cwp        <= '0;
      cwpGray    <= '0;
      wrDropping <= 1'b0;
      ovfCount   <= '0;
      stretchCnt <= '0;
    end else begin
      // an abort rewinds only the uncommitted tail; cwp is left alone
      if (wrAbort) begin
        wp         <= cwp;
        wrDropping <= 1'b0;
      end else if (doWrite) begin
        wp <= wpInc;
        if (wpInc[FRAMELOG2-1:0] == '0) begin
          cwp     <= wpInc;
          cwpGray <= toGray(wpInc);
        end
      end else if (overflow) begin
        wrDropping <= 1'b1;
      end

      if (overflow && ovfCount != 16'hFFFF) begin
        ovfCount <= ovfCount + 16'd1;
      end

      if (overflow) begin
        stretchCnt <= '1;
      end else if (stretchCnt != '0) begin
        stretchCnt <= stretchCnt - 1'b1;
      end
    end
  end

  assign dataOverf = (stretchCnt != '0);

  always_ff @(posedge wrClk) begin
    if (doWrite) begin
      mem[wp] <= wrData;
    end
  end

  always_ff @(posedge wrClk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) rpRelGraySync[i] <= '0;
    end else begin
      rpRelGraySync[0] <= rpRelGray;
      for (int i = 1; i < SYNC_STAGES; i++) rpRelGraySync[i] <= rpRelGraySync[i-1];
    end
  end

  assign rpRelSync = fromGray(rpRelGraySync[SYNC_STAGES-1]);

  // ---------------------------------------------------------------- read side
  always_ff @(posedge rdClk) begin
    rdRstPipe <= {rdRstPipe[SYNC_STAGES-2:0], rst};
  end

  assign rdRst = rdRstPipe[SYNC_STAGES-1];

  always_ff @(posedge rdClk) begin
    if (rdRst) begin
      for (int i = 0; i < SYNC_STAGES; i++) cwpGraySync[i] <= '0;
    end else begin
      cwpGraySync[0] <= cwpGray;
      for (int i = 1; i < SYNC_STAGES; i++) cwpGraySync[i] <= cwpGraySync[i-1];
    end
  end

  assign cwpSync = fromGray(cwpGraySync[SYNC_STAGES-1]);

  // rewind beats a same-cycle consume
  always_comb begin
    consume = rdValid & rdReady & ~rdRewind;
    rpInc   = rp + 1'b1;
    if (rdRewind) begin
      rpNext = rpRel;
    end else if (consume) begin
      rpNext = rpInc;
    end else begin
      rpNext = rp;
    end
  end

  always_ff @(posedge rdClk) begin
    if (rdRst) begin
      rp        <= '0;
      rpRel     <= '0;
      rpRelGray <= '0;
      rdValid   <= 1'b0;
    end else begin
      rp      <= rpNext;
      rdValid <= (rpNext != cwpSync);
      if (consume && rpInc[FRAMELOG2-1:0] == '0) begin
        rpRel     <= rpInc;
        rpRelGray <= toGray(rpInc);
      end
    end
  end

  always_ff @(posedge rdClk) begin
    rdData <= mem[rpNext];
  end

  assign framesDiff    = cwpSync - rpRel;
  assign rdFramesAvail = FCW'(framesDiff >> FRAMELOG2);
  assign rdFrameReady  = (rdFramesAvail != '0);

endmodule

// File: tb/tb_frame_cdc_buffer.sv
// Directed bench for frame_cdc_buffer with a 32-word buffer, 8-word frames and a short
// overflow stretch so the indicator's fall can be observed.
module tb_frame_cdc_buffer;
  localparam int WIDTH = 16;
  localparam int DL    = 5;
  localparam int FL    = 3;
  localparam int SS    = 2;
  localparam int SL    = 6;

  logic             wrClk, rst, wrValid, wrAbort, wrFull, wrDropping, dataOverf;
  logic             rdClk, rdReady, rdValid, rdRewind, rdFrameReady;
  logic [WIDTH-1:0] wrData, rdData;
  logic [15:0]      ovfCount;
  logic [DL-FL:0]   rdFramesAvail;

  int wrHalf = 5;
  int rdHalf = 5;
  int checks = 0;
  int failures = 0;
  logic [15:0] rdGot[$];

  frame_cdc_buffer #(
    .WIDTH(WIDTH), .DEPTHLOG2(DL), .FRAMELOG2(FL), .SYNC_STAGES(SS), .STRETCHLOG2(SL)
  ) dut (
    .wrClk(wrClk), .rst(rst), .wrValid(wrValid), .wrData(wrData), .wrAbort(wrAbort),
    .wrFull(wrFull), .wrDropping(wrDropping), .ovfCount(ovfCount), .dataOverf(dataOverf),
    .rdClk(rdClk), .rdReady(rdReady), .rdData(rdData), .rdValid(rdValid),
    .rdRewind(rdRewind), .rdFrameReady(rdFrameReady), .rdFramesAvail(rdFramesAvail)
  );

  initial begin
    wrClk = 1'b0;
    forever #(wrHalf) wrClk = ~wrClk;
  end

  initial begin
    rdClk = 1'b0;
    #2;
    forever #(rdHalf) rdClk = ~rdClk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic doReset();
    @(negedge wrClk);
    rst = 1'b1; wrValid = 1'b0; wrAbort = 1'b0; rdReady = 1'b0; rdRewind = 1'b0;
    repeat (8) @(negedge wrClk);
    rst = 1'b0;
    repeat (SS + 4) @(negedge rdClk);
    @(negedge wrClk);
  endtask

  task automatic writeWords(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge wrClk);
      wrValid = 1'b1;
      wrData  = base + 16'(i);
    end
    @(negedge wrClk);
    wrValid = 1'b0;
  endtask

  // rdReady is raised only for a word sampled here, so every consumed word is captured
  task automatic collectWords(input int n, input int maxCycles, input bit randomReady);
    int cyc = 0;
    rdGot.delete();
    while (rdGot.size() < n && cyc < maxCycles) begin
      @(negedge rdClk);
      cyc++;
      if (rdValid && (!randomReady || $urandom_range(0, 2) != 0)) begin
        rdGot.push_back(rdData);
        rdReady = 1'b1;
      end else begin
        rdReady = 1'b0;
      end
    end
    @(negedge rdClk);
    rdReady = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checks++; if (wrFull !== 1'b0) begin failures++; $display("FAIL %s_wrFull got=%0b exp=0", tag, wrFull); end
    checks++; if (wrDropping !== 1'b0) begin failures++; $display("FAIL %s_wrDropping got=%0b exp=0", tag, wrDropping); end
    checks++; if (ovfCount !== 16'h0) begin failures++; $display("FAIL %s_ovfCount got=%0h exp=0", tag, ovfCount); end
    checks++; if (dataOverf !== 1'b0) begin failures++; $display("FAIL %s_dataOverf got=%0b exp=0", tag, dataOverf); end
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL %s_rdValid got=%0b exp=0", tag, rdValid); end
    checks++; if (rdFrameReady !== 1'b0) begin failures++; $display("FAIL %s_rdFrameReady got=%0b exp=0", tag, rdFrameReady); end
    checks++; if (rdFramesAvail !== 0) begin failures++; $display("FAIL %s_rdFramesAvail got=%0d exp=0", tag, rdFramesAvail); end
  endtask

  task automatic test_reset();
    doReset();
    checkIdle("reset");
  endtask

  task automatic test_basic();
    int waited = 0;
    writeWords(16'h0001, 8);
    while (!rdFrameReady && waited < SS + 3) begin
      @(negedge rdClk);
      waited++;
    end
    checks++; if (rdFrameReady !== 1'b1) begin failures++; $display("FAIL basic_frame_ready got=%0b exp=1", rdFrameReady); end
    checks++; if (rdFramesAvail !== 1) begin failures++; $display("FAIL basic_avail_before got=%0d exp=1", rdFramesAvail); end
    collectWords(8, 40, 1'b0);
    checks++; if (rdGot.size() != 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", rdGot.size()); end
    foreach (rdGot[i]) begin
      checks++; if (rdGot[i] !== 16'(i + 1)) begin failures++; $display("FAIL basic_word%0d got=%0h exp=%0h", i, rdGot[i], i + 1); end
    end
    checks++; if (rdFramesAvail !== 0) begin failures++; $display("FAIL basic_avail_after got=%0d exp=0", rdFramesAvail); end
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%0b exp=0", rdValid); end
  endtask

  task automatic test_abort();
    bit sawValid = 1'b0;
    writeWords(16'h0050, 5);
    @(negedge wrClk); wrAbort = 1'b1;
    @(negedge wrClk); wrAbort = 1'b0;
    repeat (12) begin
      @(negedge rdClk);
      if (rdValid) sawValid = 1'b1;
    end
    checks++; if (sawValid) begin failures++; $display("FAIL abort_no_valid got=1 exp=0"); end
    writeWords(16'h00A0, 8);
    collectWords(8, 40, 1'b0);
    checks++; if (rdGot.size() != 8) begin failures++; $display("FAIL abort_count got=%0d exp=8", rdGot.size()); end
    foreach (rdGot[i]) begin
      checks++; if (rdGot[i] !== 16'h00A0 + 16'(i)) begin failures++; $display("FAIL abort_word%0d got=%0h exp=%0h", i, rdGot[i], 16'h00A0 + 16'(i)); end
    end
    repeat (10) @(negedge rdClk);
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL abort_tail_valid got=%0b exp=0", rdValid); end
    checks++; if (rdFramesAvail !== 0) begin failures++; $display("FAIL abort_avail got=%0d exp=0", rdFramesAvail); end
  endtask

  task automatic test_rewind();
    writeWords(16'h00B0, 8);
    collectWords(5, 40, 1'b0);
    checks++; if (rdData !== 16'h00B5) begin failures++; $display("FAIL rewind_pre got=%0h exp=b5", rdData); end
    rdRewind = 1'b1;
    @(negedge rdClk);
    rdRewind = 1'b0;
    checks++; if (rdData !== 16'h00B0 || rdValid !== 1'b1) begin failures++; $display("FAIL rewind_first got=%0h/%0b exp=b0/1", rdData, rdValid); end
    collectWords(2, 20, 1'b0);
    rdRewind = 1'b1; rdReady = 1'b1;
    @(negedge rdClk);
    rdRewind = 1'b0; rdReady = 1'b0;
    checks++; if (rdData !== 16'h00B0) begin failures++; $display("FAIL rewind_with_ready got=%0h exp=b0", rdData); end
    collectWords(8, 40, 1'b0);
    checks++; if (rdGot.size() != 8) begin failures++; $display("FAIL rewind_count got=%0d exp=8", rdGot.size()); end
    foreach (rdGot[i]) begin
      checks++; if (rdGot[i] !== 16'h00B0 + 16'(i)) begin failures++; $display("FAIL rewind_word%0d got=%0h exp=%0h", i, rdGot[i], 16'h00B0 + 16'(i)); end
    end
    checks++; if (rdFramesAvail !== 0) begin failures++; $display("FAIL rewind_avail got=%0d exp=0", rdFramesAvail); end
  endtask

  task automatic test_overflow();
    writeWords(16'h0C00, 30);
    checks++; if (wrFull !== 1'b0) begin failures++; $display("FAIL ovf_not_full30 got=%0b exp=0", wrFull); end
    writeWords(16'h0C00 + 16'd30, 1);
    checks++; if (wrFull !== 1'b1) begin failures++; $display("FAIL ovf_full31 got=%0b exp=1", wrFull); end
    checks++; if (wrDropping !== 1'b0 || ovfCount !== 16'h0) begin failures++; $display("FAIL ovf_pre got=%0b/%0h exp=0/0", wrDropping, ovfCount); end
    writeWords(16'h0C00 + 16'd31, 9);
    checks++; if (wrDropping !== 1'b1) begin failures++; $display("FAIL ovf_dropping got=%0b exp=1", wrDropping); end
    checks++; if (ovfCount !== 16'h1) begin failures++; $display("FAIL ovf_count got=%0h exp=1", ovfCount); end
    checks++; if (dataOverf !== 1'b1) begin failures++; $display("FAIL ovf_stretch_on got=%0b exp=1", dataOverf); end
    repeat (54) @(negedge wrClk);
    checks++; if (dataOverf !== 1'b1) begin failures++; $display("FAIL ovf_stretch_last got=%0b exp=1", dataOverf); end
    @(negedge wrClk);
    checks++; if (dataOverf !== 1'b0) begin failures++; $display("FAIL ovf_stretch_off got=%0b exp=0", dataOverf); end
    checks++; if (rdFramesAvail !== 3) begin failures++; $display("FAIL ovf_frames got=%0d exp=3", rdFramesAvail); end
    wrAbort = 1'b1;
    @(negedge wrClk);
    wrAbort = 1'b0;
    checks++; if (wrDropping !== 1'b0 || wrFull !== 1'b0) begin failures++; $display("FAIL ovf_abort got=%0b/%0b exp=0/0", wrDropping, wrFull); end
    collectWords(24, 100, 1'b0);
    checks++; if (rdGot.size() != 24) begin failures++; $display("FAIL ovf_read_count got=%0d exp=24", rdGot.size()); end
    foreach (rdGot[i]) begin
      checks++; if (rdGot[i] !== 16'h0C00 + 16'(i)) begin failures++; $display("FAIL ovf_word%0d got=%0h exp=%0h", i, rdGot[i], 16'h0C00 + 16'(i)); end
    end
    writeWords(16'h00D0, 8);
    collectWords(8, 40, 1'b0);
    checks++; if (rdGot.size() != 8) begin failures++; $display("FAIL ovf_resume_count got=%0d exp=8", rdGot.size()); end
    foreach (rdGot[i]) begin
      checks++; if (rdGot[i] !== 16'h00D0 + 16'(i)) begin failures++; $display("FAIL ovf_resume%0d got=%0h exp=%0h", i, rdGot[i], 16'h00D0 + 16'(i)); end
    end
    checks++; if (ovfCount !== 16'h1) begin failures++; $display("FAIL ovf_count_hold got=%0h exp=1", ovfCount); end
  endtask

  task automatic test_stream(input int wh, input int rh, input logic [15:0] base);
    int sent = 0;
    int wcyc = 0;
    int errs = 0;
    wrHalf = wh; rdHalf = rh;
    repeat (4) @(negedge wrClk);
    fork
      begin
        while (sent < 96 && wcyc < 3000) begin
          @(negedge wrClk);
          wcyc++;
          if (!wrFull) begin
            wrValid = 1'b1;
            wrData  = base + 16'(sent);
            sent++;
          end else begin
            wrValid = 1'b0;
          end
        end
        @(negedge wrClk);
        wrValid = 1'b0;
      end
      collectWords(96, 6000, 1'b1);
    join
    checks++; if (sent != 96) begin failures++; $display("FAIL stream_%0h_sent got=%0d exp=96", base, sent); end
    checks++; if (rdGot.size() != 96) begin failures++; $display("FAIL stream_%0h_count got=%0d exp=96", base, rdGot.size()); end
    foreach (rdGot[i]) begin
      checks++;
      if (rdGot[i] !== base + 16'(i)) begin
        failures++;
        if (errs < 4) $display("FAIL stream_%0h_word%0d got=%0h exp=%0h", base, i, rdGot[i], base + 16'(i));
        errs++;
      end
    end
    checks++; if (wrDropping !== 1'b0 || ovfCount !== 16'h1) begin failures++; $display("FAIL stream_%0h_no_drop got=%0b/%0h exp=0/1", base, wrDropping, ovfCount); end
    wrHalf = 5; rdHalf = 5;
    repeat (4) @(negedge wrClk);
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    writeWords(16'h0E00, 19);
    while (rdFramesAvail != 2 && waited < 20) begin
      @(negedge rdClk);
      waited++;
    end
    checks++; if (rdFramesAvail !== 2) begin failures++; $display("FAIL rstmid_frames got=%0d exp=2", rdFramesAvail); end
    doReset();
    checkIdle("rstmid");
    writeWords(16'h00E0, 8);
    collectWords(8, 40, 1'b0);
    checks++; if (rdGot.size() != 8) begin failures++; $display("FAIL rstmid_count got=%0d exp=8", rdGot.size()); end
    foreach (rdGot[i]) begin
      checks++; if (rdGot[i] !== 16'h00E0 + 16'(i)) begin failures++; $display("FAIL rstmid_word%0d got=%0h exp=%0h", i, rdGot[i], 16'h00E0 + 16'(i)); end
    end
  endtask

  initial begin
    rst = 1'b1; wrValid = 1'b0; wrData = '0; wrAbort = 1'b0; rdReady = 1'b0; rdRewind = 1'b0;
    test_reset();
    test_basic();
    test_abort();
    test_rewind();
    test_overflow();
    test_stream(7, 3, 16'h1000);
    test_stream(3, 7, 16'h2000);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
